// File: rtl/sipo_frame_ctrl_pkg.sv
// Purpose : shared types and line constants for the serial frame receiver.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (receiver FSM states), START_BIT / STOP_BIT line levels.
package sipo_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Purpose : parallel word output stream of the frame receiver.
// Latency : n/a (wires only).
// Backpressure: data_dat/data_out held while data_valid until data_ready.
// Ports   : data_out (word), data_valid (word present), data_ready (consumer accepts).
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/sipo_shift_reg.sv
// Purpose : serial-in/parallel-out shifter for in-flight frame data bits.
// Latency : q updates on the edge where shift_en is sampled high.
// Backpressure: none; holds state while shift_en=0.
// Ports   : clk, rst, clear (sync), shift_en, serial_in -> q (first bit ends in MSB).
module sipo_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (shift_en) begin
            // New bit enters at bit 0; earlier bits move toward the MSB.
            q <= {q[WIDTH-2:0], serial_in};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Purpose : receives start/data/parity/stop serial frames and presents each good word.
// Latency : data_valid/data_out update on the edge sampling a good stop bit.
// Backpressure: one-entry buffer; a good word arriving while it is full and not draining is dropped (overrun).
// Ports   : clk, rst (sync, active high), serial_in, bit_en, out_if (word stream),
//           busy, parity_err, frame_err, overrun (sticky), clr_err.
module sipo_frame_ctrl
    import sipo_frame_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      serial_in,
    input  logic                      bit_en,
    sipo_frame_ctrl_if.master         out_if,
    output logic                      busy,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      overrun,
    input  logic                      clr_err
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic               par_bad;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   dout_q;
    logic               dvld_q;
    logic               shift_en;
    logic               shift_clr;
    logic               stop_good;

    assign shift_en  = bit_en && (state == S_SHIFT);
    assign shift_clr = bit_en && (state == S_IDLE) && (serial_in == START_BIT);
    assign stop_good = (serial_in == STOP_BIT) && !par_bad;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clear     (shift_clr),
        .shift_en  (shift_en),
        .serial_in (serial_in),
        .q         (shift_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            par_bad    <= 1'b0;
            busy       <= 1'b0;
            dout_q     <= '0;
            dvld_q     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Defaults first: drain and clear; later assignments (load, flag set) win.
            if (dvld_q && out_if.data_ready) begin
                dvld_q <= 1'b0;
            end
            if (clr_err) begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end

            if (bit_en) begin
                case (state)
                    S_IDLE: begin
                        if (serial_in == START_BIT) begin
                            state   <= S_SHIFT;
                            bit_cnt <= '0;
                            par_bad <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_LAST) begin
                            state <= PARITY_EN ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        // Even parity: data bits plus parity bit must XOR to 0.
                        par_bad <= (^shift_q) ^ serial_in;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (par_bad) begin
                            parity_err <= 1'b1;
                        end
                        if (serial_in != STOP_BIT) begin
                            frame_err <= 1'b1;
                        end
                        if (stop_good) begin
                            if (!dvld_q || out_if.data_ready) begin
                                dout_q <= shift_q;
                                dvld_q <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_if.data_out   = dout_q;
    assign out_if.data_valid = dvld_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic serial_in;
    logic bit_en;
    logic clr_err;
    logic busy;
    logic perr;
    logic ferr;
    logic ovr;

    int total = 0;
    int bad   = 0;

    sipo_frame_ctrl_if #(.WIDTH(4)) oif ();

    sipo_frame_ctrl #(
        .WIDTH     (4),
        .PARITY_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_en     (bit_en),
        .out_if     (oif.master),
        .busy       (busy),
        .parity_err (perr),
        .frame_err  (ferr),
        .overrun    (ovr),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pre_rdy;
        logic       clr;
        logic [0:6] bits;
        logic       rdy;
        logic       exp_vld;
        logic [3:0] exp_dat;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [3:0] dat,
                             input logic pe, input logic fe, input logic ov);
        chk({tag, "_vld"},  32'(oif.data_valid), 32'(vld));
        if (vld) chk({tag, "_dat"}, 32'(oif.data_out), 32'(dat));
        chk({tag, "_perr"}, 32'(perr), 32'(pe));
        chk({tag, "_ferr"}, 32'(ferr), 32'(fe));
        chk({tag, "_ovr"},  32'(ovr),  32'(ov));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bit_en = 1'b0; serial_in = 1'b1; oif.data_ready = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends start, 4 data, parity, stop with 'gap' idle cycles between strobes;
    // returns at the negedge after the stop strobe with inputs idled.
    task automatic send_frame(input logic [0:6] bits, input logic rdy_body, input logic rdy_stop,
                              input int gap, input logic clr_stop);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i > 0) chk("busy_mid", 32'(busy), 32'd1);
            serial_in      = bits[i];
            bit_en         = 1'b1;
            oif.data_ready = (i == 6) ? rdy_stop : rdy_body;
            clr_err        = (i == 6) ? clr_stop : 1'b0;
            if (i < 6) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("busy_gap", 32'(busy), 32'd1);
                    bit_en    = 1'b0;
                    serial_in = ~bits[i];
                end
            end
        end
        @(negedge clk);
        bit_en = 1'b0; serial_in = 1'b1; oif.data_ready = 1'b0; clr_err = 1'b0;
    endtask

    // Frame-level reference state for the random phase.
    logic       m_vld;
    logic [3:0] m_dat;
    logic       m_perr, m_ferr, m_ovr;

    initial begin
        rst = 1'b1; serial_in = 1'b1; bit_en = 1'b0; clr_err = 1'b0; oif.data_ready = 1'b0;

        //                pre clr bits        rdy vld dat      pe fe ov
        vecs[0] = '{1'b1, 1'b0, 7'b0101111, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 7'b0101101, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 7'b0001100, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 7'b0001101, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 7'b0101111, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 7'b0010011, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 7'b0111101, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0};

        // Reset state
        do_reset();
        chk("rst_vld",  32'(oif.data_valid), 32'd0);
        chk("rst_dat",  32'(oif.data_out),   32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_ovr",  32'(ovr),  32'd0);

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            oif.data_ready = vecs[v].pre_rdy;
            clr_err        = vecs[v].clr;
            bit_en         = 1'b0;
            serial_in      = 1'b1;
            send_frame(vecs[v].bits, vecs[v].rdy, vecs[v].rdy, 0, 1'b0);
            check_out($sformatf("vec%0d", v), vecs[v].exp_vld, vecs[v].exp_dat,
                      vecs[v].exp_perr, vecs[v].exp_ferr, vecs[v].exp_ovr);
        end

        // Overrun, then a single drain empties the buffer
        do_reset();
        send_frame(7'b0101111, 1'b0, 1'b0, 0, 1'b0);
        send_frame(7'b0010011, 1'b0, 1'b0, 0, 1'b0);
        check_out("ovr", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
        oif.data_ready = 1'b1;
        @(negedge clk);
        oif.data_ready = 1'b0;
        chk("ovr_drain_vld", 32'(oif.data_valid), 32'd0);
        chk("ovr_drain_ovr", 32'(ovr), 32'd1);

        // Drain and load on the same stop edge
        do_reset();
        send_frame(7'b0101111, 1'b0, 1'b0, 0, 1'b0);
        send_frame(7'b0010011, 1'b0, 1'b1, 0, 1'b0);
        check_out("simul", 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);

        // clr_err clears; a set on the same edge as clr_err wins
        do_reset();
        send_frame(7'b0101101, 1'b1, 1'b1, 0, 1'b0);
        chk("perr_set", 32'(perr), 32'd1);
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("perr_clr", 32'(perr), 32'd0);
        send_frame(7'b0101101, 1'b1, 1'b1, 0, 1'b1);
        chk("perr_set_wins", 32'(perr), 32'd1);

        // Reset mid-frame discards frame and buffered word
        do_reset();
        send_frame(7'b0101111, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            serial_in = (i == 1) ? 1'b1 : 1'b0;
            bit_en    = 1'b1;
        end
        @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1; bit_en = 1'b0; serial_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_vld",  32'(oif.data_valid), 32'd0);
        chk("midrst_dat",  32'(oif.data_out),   32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        send_frame(7'b0101111, 1'b0, 1'b0, 0, 1'b0);
        check_out("midrst_after", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);

        // bit_en every 4th cycle, line toggled in the gaps
        do_reset();
        send_frame(7'b0101111, 1'b0, 1'b0, 3, 1'b0);
        check_out("slow", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);

        // Random frames against a frame-level model
        do_reset();
        m_vld = 1'b0; m_dat = '0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic       r, clr, pinj, finj;
            logic [3:0] d;
            logic [0:6] fb;
            int         k;
            r    = 1'($urandom % 2);
            clr  = ($urandom % 4) == 0;
            pinj = ($urandom % 4) == 0;
            finj = ($urandom % 4) == 0;
            d    = 4'($urandom);
            k    = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                @(negedge clk);
                serial_in      = 1'b1;
                bit_en         = 1'($urandom % 2);
                oif.data_ready = r;
                clr_err        = (j == 0) ? clr : 1'b0;
            end
            if (r) m_vld = 1'b0;
            if (clr) begin m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; end
            fb = {1'b0, d, (^d) ^ pinj, ~finj};
            send_frame(fb, r, r, $urandom_range(0, 2), 1'b0);
            if (pinj) m_perr = 1'b1;
            if (finj) m_ferr = 1'b1;
            if (!pinj && !finj) begin
                if (m_vld) m_ovr = 1'b1;
                else begin m_vld = 1'b1; m_dat = d; end
            end
            check_out($sformatf("rnd%0d", n), m_vld, m_dat, m_perr, m_ferr, m_ovr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Frame-level controller that sequences a serial-in/parallel-out shifter to receive asynchronous-style serial frames (start bit, WIDTH data bits, optional even parity, stop bit). Sits between the serial input pin logic and the parallel consumer, and presents each completed word through a one-entry valid/ready output buffer. The block owns the bit count, frame checking and error flags; the shifter holds only the in-flight data bits.

## Interface
- WIDTH, 4: data bits per frame, at least 2
- PARITY_EN, 1: 1 means an even-parity bit follows the data bits; 0 means no parity bit
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- serial_in  in  1  serial line, idle high
- bit_en  in  1  one-cycle sample strobe; serial_in is sampled only when bit_en=1
- data_out  out  WIDTH  received word, held stable while data_valid=1
- data_valid  out  1  buffer holds an unconsumed word
- data_ready  in  1  consumer accepts the word when data_valid & data_ready
- busy  out  1  FSM is not IDLE
- parity_err  out  1  sticky; set on a parity mismatch
- frame_err  out  1  sticky; set when the stop bit is 0
- overrun  out  1  sticky; set when a good word arrives while the buffer is full and not draining
- clr_err  in  1  clears all three sticky flags

## Operation
- FSM states are IDLE, SHIFT, PARITY and STOP. All transitions occur only on cycles with bit_en=1.
- IDLE: if serial_in=0 (start bit), go to SHIFT and clear bit_cnt.
- SHIFT: shift serial_in into the shifter at bit 0, with existing bits moving toward the MSB. The first data bit ends in data_out[WIDTH-1]. Increment bit_cnt. After the WIDTH-th bit, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: sample the parity bit. If the XOR of the WIDTH data bits and the parity bit is 1, the word is bad. Go to STOP.
- STOP:
  - serial_in=1 and no parity error: the word is good; perform a buffer load.
  - serial_in=0: set frame_err and discard the word.
  - Parity error: set parity_err and discard the word. This applies even when the stop bit is good.
  - Always return to IDLE.
- Buffer load:
  - Buffer empty, or data_valid & data_ready in the same cycle: data_out takes the shifter value and data_valid is 1.
  - Otherwise: set overrun, drop the new word, and leave data_out unchanged.
- Handshake:
  - data_valid stays high until data_ready is sampled high.
  - A transfer occurs on an edge where data_valid & data_ready, which clears data_valid unless a load happens on the same edge.
  - data_ready is ignored while data_valid=0.
- Flag priority: setting a flag wins over clr_err on the same edge.
- bit_en=0 cycles hold all FSM, counter and shifter state.

## Timing
- Reset values: data_out=0, data_valid=0, busy=0, parity_err=0, frame_err=0, overrun=0. The FSM goes to IDLE, and bit_cnt and the shifter are cleared.
- rst is asserted mid-frame: abort the frame, discard any buffered word, and resume in IDLE on the next cycle. rst has priority over every other input.
- Latency: data_valid and data_out update on the same rising edge that samples a good stop bit. They are visible in the following cycle.
- busy rises on the edge that samples the start bit and falls on the edge that samples the stop bit.
- bit_en held high continuously is legal; a back-to-back frame then starts on the next bit_en.
- Frame length is 2 + WIDTH + PARITY_EN bit_en strobes.
- bit_cnt width is $clog2(WIDTH+1) and it never wraps within a frame.

## Structure
- The shared package holds:
  - the state typedef, a 2-bit enum with S_IDLE, S_SHIFT, S_PARITY and S_STOP
  - the constants START_BIT=0 and STOP_BIT=1
- One sub-module, sipo_shift_reg, is a WIDTH-parameterised shifter with a shift-enable and a synchronous clear.
  - It shifts when shift_en=1, using the same bit ordering described above.
  - The controller drives its shift_en and clear, and holds the FSM, counter, parity, output buffer and flags.

## Test plan
All scenarios use WIDTH=4, PARITY_EN=1, bit_en every cycle and data_ready=1 unless stated.
- Good frame 0,1,0,1,1,1,1 (start, data, parity, stop): data_out=4'b1011 with data_valid=1 one cycle after the stop edge. No flags are set.
- Bad parity frame 0,1,0,1,1,0,1: data_valid stays 0 and parity_err=1. clr_err then clears parity_err on the next edge.
- Framing error frame 0,0,0,1,1,0,0: frame_err=1 with no data_valid. A following good frame is received normally, giving data_out=4'b0011.
- Overrun: hold data_ready=0 and send two good frames, 4'b1011 then 4'b0100. The result is overrun=1 with data_out still 4'b1011. Raising data_ready then gives one transfer and data_valid=0.
- Simultaneous drain and load: assert data_ready on the exact stop edge of a second frame. data_valid stays 1, data_out changes to the new word, and overrun stays 0.
- Reset mid-frame: assert rst after 2 data bits. All outputs go to 0 and busy=0. A subsequent full frame yields the correct word.
- Variant: with bit_en=1 only every 4th cycle, results match the good-frame scenario, and state is unchanged on the gap cycles.
